// File: rtl/data_memory_ctrl.sv
// Data memory with byte-lane writes, sign/zero-extended loads and a registered read.
// A valid/ready request port feeds a two-beat FSM that splits accesses crossing a word.
module data_memory_ctrl #(
    parameter int SIZE        = 256,
    parameter bit MISALIGN_EN = 1'b1,
    localparam int LOGSIZE    = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [LOGSIZE+1:0]   req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_fault
);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    localparam logic [LOGSIZE-1:0] IDX_ONE = LOGSIZE'(1);

    state_t               state_q, state_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 we_q, we_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic                 fault_q, fault_d;
    logic                 split_q, split_d;
    logic [LOGSIZE-1:0]   idx_q, idx_d;
    logic [3:0]           be_hi_q, be_hi_d;
    logic [31:0]          wdata_hi_q, wdata_hi_d;
    logic [31:0]          lo_word_q, lo_word_d;

    logic [1:0]           req_off;
    logic [LOGSIZE-1:0]   req_idx;
    logic [3:0]           req_mask;
    logic [2:0]           req_size;
    logic                 req_cross;
    logic                 req_illegal;
    logic                 req_fault;
    logic [7:0]           req_be;
    logic [63:0]          req_wdata_sh;
    logic                 accept;

    logic [LOGSIZE-1:0]   mem_idx;
    logic [3:0]           mem_we;
    logic [31:0]          mem_wdata;
    logic [31:0]          rd_word;

    logic [63:0]          rsp_pair;
    logic [31:0]          rsp_raw;
    logic [31:0]          rsp_ext;

    // Byte enables and data are laid out over a 64-bit window spanning word idx and idx+1.
    always_comb begin
        req_off = req_addr[1:0];
        req_idx = req_addr[LOGSIZE+1:2];
        case (req_funct3[1:0])
            2'b00:   begin req_mask = 4'b0001; req_size = 3'd1; end
            2'b01:   begin req_mask = 4'b0011; req_size = 3'd2; end
            default: begin req_mask = 4'b1111; req_size = 3'd4; end
        endcase
        req_cross    = ({1'b0, req_off} + req_size) > 3'd4;
        req_illegal  = req_we ? (req_funct3 >= 3'b011)
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        req_fault    = req_illegal || (req_cross && !MISALIGN_EN);
        req_be       = {4'b0000, req_mask} << req_off;
        req_wdata_sh = {32'h0000_0000, req_wdata} << {req_off, 3'b000};
    end

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        fault_d     = fault_q;
        split_d     = split_q;
        idx_d       = idx_q;
        be_hi_d     = be_hi_q;
        wdata_hi_d  = wdata_hi_q;
        lo_word_d   = lo_word_q;
        mem_idx     = req_idx;
        mem_we      = 4'b0000;
        mem_wdata   = req_wdata_sh[31:0];

        if (state_q == IDLE) begin
            if (accept) begin
                we_d       = req_we;
                funct3_d   = req_funct3;
                off_d      = req_off;
                fault_d    = req_fault;
                split_d    = req_cross && !req_fault;
                idx_d      = req_idx;
                be_hi_d    = req_be[7:4];
                wdata_hi_d = req_wdata_sh[63:32];
                if (!req_fault && req_we) begin
                    mem_we = req_be[3:0];
                end
                if (req_cross && !req_fault) begin
                    state_d = SECOND;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
        end else begin
            // Second beat: the low word read last edge is parked while word idx+1 is read.
            mem_idx     = idx_q + IDX_ONE;
            mem_wdata   = wdata_hi_q;
            mem_we      = (we_q && !reset) ? be_hi_q : 4'b0000;
            lo_word_d   = rd_word;
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            fault_q     <= 1'b0;
            split_q     <= 1'b0;
            idx_q       <= '0;
            be_hi_q     <= 4'b0000;
            wdata_hi_q  <= 32'h0;
            lo_word_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            fault_q     <= fault_d;
            split_q     <= split_d;
            idx_q       <= idx_d;
            be_hi_q     <= be_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            lo_word_q   <= lo_word_d;
        end
    end

    // One byte-wide RAM per lane so each lane has its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [SIZE];
        logic [7:0] rd_byte_q;

        always_ff @(posedge clk) begin
            if (mem_we[gi]) begin
                lane_mem[mem_idx] <= mem_wdata[8*gi +: 8];
            end
            rd_byte_q <= lane_mem[mem_idx];
        end

        assign rd_word[8*gi +: 8] = rd_byte_q;
    end

    always_comb begin
        rsp_pair = split_q ? {rd_word, lo_word_q} : {32'h0000_0000, rd_word};
        rsp_raw  = 32'(rsp_pair >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  rsp_ext = {{24{rsp_raw[7]}}, rsp_raw[7:0]};
            3'b001:  rsp_ext = {{16{rsp_raw[15]}}, rsp_raw[15:0]};
            3'b010:  rsp_ext = rsp_raw;
            3'b100:  rsp_ext = {24'h0, rsp_raw[7:0]};
            3'b101:  rsp_ext = {16'h0, rsp_raw[15:0]};
            default: rsp_ext = 32'h0;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_valid_q && fault_q;
    assign rsp_rdata = (rsp_valid_q && !fault_q && !we_q) ? rsp_ext : 32'h0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: dut0 splits crossing accesses, dut1 faults them.
// Both instances use SIZE=16 so word wrap is reachable.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [5:0]  req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_fault  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        data_memory_ctrl #(
            .SIZE        (16),
            .MISALIGN_EN ((gi == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[gi]),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_we     (req_we[gi]),
            .req_funct3 (req_funct3[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .rsp_valid  (rsp_valid[gi]),
            .rsp_rdata  (rsp_rdata[gi]),
            .rsp_fault  (rsp_fault[gi])
        );
    end

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } exp_t;

    typedef struct {
        int d;
        bit v;
        int due;
    } rdy_t;

    exp_t sb [2][$];
    rdy_t rq [$];
    exp_t e;
    rdy_t r;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // lat: cycles from drive to the response (1 = one beat, 2 = split, 0 = none expected)
    task automatic issue(input int d, input bit we, input logic [2:0] f3, input logic [5:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input bit ef, input int lat);
        exp_t x;
        int   n = 0;
        @(posedge clk); #1;
        req_valid[1-d] = 1'b0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        if (lat > 0) begin
            x.rdata = er;
            x.fault = ef;
            x.due   = cyc + lat;
            sb[d].push_back(x);
        end
    endtask

    task automatic expect_ready(input int d, input bit v, input int due);
        rdy_t x;
        x.d = d; x.v = v; x.due = due;
        rq.push_back(x);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_funct3[d] = 3'b000; req_addr[d] = 6'h00; req_wdata[d] = 32'h0;
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        expect_ready(0, 1'b0, cyc);
        expect_ready(1, 1'b0, cyc);
        @(posedge clk); #1;
        reset[0] = 1'b0; reset[1] = 1'b0;
        expect_ready(0, 1'b1, cyc);
        expect_ready(1, 1'b1, cyc);

        // aligned word store/load
        issue(0, 1, 3'b010, 6'h0C, 32'hDEADBEEF, 32'h0, 0, 1);
        issue(0, 0, 3'b010, 6'h0C, 32'h0, 32'hDEADBEEF, 0, 1);
        // extensions, back to back
        issue(0, 1, 3'b010, 6'h10, 32'h3210F0F0, 32'h0, 0, 1);
        issue(0, 0, 3'b001, 6'h10, 32'h0, 32'hFFFFF0F0, 0, 1);
        issue(0, 0, 3'b101, 6'h10, 32'h0, 32'h0000F0F0, 0, 1);
        issue(0, 0, 3'b000, 6'h10, 32'h0, 32'hFFFFFFF0, 0, 1);
        issue(0, 0, 3'b100, 6'h10, 32'h0, 32'h000000F0, 0, 1);
        // non-crossing half store at offset 1
        issue(0, 1, 3'b010, 6'h04, 32'h11223344, 32'h0, 0, 1);
        issue(0, 1, 3'b001, 6'h05, 32'h0000AABB, 32'h0, 0, 1);
        issue(0, 0, 3'b010, 6'h04, 32'h0, 32'h11AABB44, 0, 1);
        // split load and store
        issue(0, 1, 3'b010, 6'h00, 32'h44332211, 32'h0, 0, 1);
        issue(0, 1, 3'b010, 6'h04, 32'h88776655, 32'h0, 0, 1);
        issue(0, 0, 3'b010, 6'h02, 32'h0, 32'h66554433, 0, 2);
        expect_ready(0, 1'b0, cyc + 1);
        expect_ready(0, 1'b1, cyc + 2);
        issue(0, 1, 3'b010, 6'h03, 32'hCAFEF00D, 32'h0, 0, 2);
        issue(0, 0, 3'b010, 6'h00, 32'h0, 32'h0D332211, 0, 1);
        issue(0, 0, 3'b010, 6'h04, 32'h0, 32'h88CAFEF0, 0, 1);
        // wrap from word 15 to word 0
        issue(0, 1, 3'b010, 6'h3C, 32'hAB000000, 32'h0, 0, 1);
        issue(0, 1, 3'b010, 6'h00, 32'h000000CD, 32'h0, 0, 1);
        issue(0, 0, 3'b001, 6'h3F, 32'h0, 32'hFFFFCDAB, 0, 2);
        // illegal funct3 on the splitting instance
        issue(0, 0, 3'b110, 6'h00, 32'h0, 32'h0, 1, 1);
        issue(0, 1, 3'b011, 6'h00, 32'hFFFFFFFF, 32'h0, 1, 1);
        issue(0, 0, 3'b010, 6'h00, 32'h0, 32'h000000CD, 0, 1);

        // faulting instance
        issue(1, 1, 3'b010, 6'h00, 32'h12345678, 32'h0, 0, 1);
        issue(1, 0, 3'b010, 6'h01, 32'h0, 32'h0, 1, 1);
        issue(1, 1, 3'b001, 6'h03, 32'h0000FFFF, 32'h0, 1, 1);
        issue(1, 1, 3'b011, 6'h00, 32'hFFFFFFFF, 32'h0, 1, 1);
        issue(1, 0, 3'b111, 6'h00, 32'h0, 32'h0, 1, 1);
        issue(1, 0, 3'b001, 6'h01, 32'h0, 32'h00003456, 0, 1);
        issue(1, 0, 3'b010, 6'h00, 32'h0, 32'h12345678, 0, 1);

        // reset during the second beat of a split store
        issue(0, 1, 3'b010, 6'h20, 32'h11111111, 32'h0, 0, 1);
        issue(0, 1, 3'b010, 6'h24, 32'h22222222, 32'h0, 0, 1);
        issue(0, 1, 3'b010, 6'h22, 32'hAABBCCDD, 32'h0, 0, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset[0] = 1'b1;
        expect_ready(0, 1'b0, cyc + 1);
        @(posedge clk);
        @(posedge clk); #1;
        reset[0] = 1'b0;
        expect_ready(0, 1'b1, cyc);
        issue(0, 0, 3'b010, 6'h20, 32'h0, 32'hCCDD1111, 0, 1);
        issue(0, 0, 3'b010, 6'h24, 32'h0, 32'h22222222, 0, 1);

        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        done = 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d] === 1'b1) begin
                    n_cmp++;
                    if (sb[d].size() == 0) begin
                        n_bad++;
                        $display("FAIL rsp_unexpected dut%0d cyc=%0d: got rdata=0x%08h fault=%0b, want no response",
                                 d, cyc, rsp_rdata[d], rsp_fault[d]);
                    end else begin
                        e = sb[d].pop_front();
                        $display("rsp dut%0d cyc=%0d rdata=0x%08h fault=%0b", d, cyc, rsp_rdata[d], rsp_fault[d]);
                        if (cyc != e.due || rsp_rdata[d] !== e.rdata || rsp_fault[d] !== e.fault) begin
                            n_bad++;
                            $display("FAIL rsp dut%0d: got rdata=0x%08h fault=%0b cyc=%0d, want rdata=0x%08h fault=%0b cyc=%0d",
                                     d, rsp_rdata[d], rsp_fault[d], cyc, e.rdata, e.fault, e.due);
                        end
                    end
                end else begin
                    n_cmp++;
                    if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_fault[d] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL idle_outputs dut%0d cyc=%0d: got valid=%0b rdata=0x%08h fault=%0b, want all 0",
                                 d, cyc, rsp_valid[d], rsp_rdata[d], rsp_fault[d]);
                    end
                    if (sb[d].size() > 0 && sb[d][0].due < cyc) begin
                        e = sb[d].pop_front();
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_missing dut%0d cyc=%0d: got no response, want rdata=0x%08h fault=%0b at cyc %0d",
                                 d, cyc, e.rdata, e.fault, e.due);
                    end
                end
            end
            while (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                n_cmp++;
                if (r.due != cyc || req_ready[r.d] !== r.v) begin
                    n_bad++;
                    $display("FAIL req_ready dut%0d cyc=%0d: got %0b, want %0b at cyc %0d",
                             r.d, cyc, req_ready[r.d], r.v, r.due);
                end
            end
            if (done && sb[0].size() == 0 && sb[1].size() == 0 && rq.size() == 0) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (cyc > 4000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout cyc=%0d: got pending=%0d, want 0", cyc, sb[0].size() + sb[1].size() + rq.size());
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

endmodule
